sar_cmp_responder: RTL and testbench

//  Digital comparator/DAC responder for the SAR conversion loop, i.e. the other end of sarlogic's d/bitout interface.
//  - Holds a synthetic 12-bit "analog" input code and answers each trial code with a comparator decision.
//  - Checks every finished conversion against the held input and keeps pass/error counters.
//  - Sits beside sarlogic inside the TT wrapper as an on-chip BIST loopback; selected in place of ui_in[0].

---
 rtl/sar_pkg.sv | 36 +++
 rtl/sar_cmp_responder_if.sv | 11 +
 rtl/sar_stim_gen.sv | 49 ++++
 rtl/sar_cmp_responder.sv | 155 +++++++++++++++
 tb/tb_sar_cmp_responder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR BIST responder: widths, stimulus modes,
// LFSR constants and the responder state encoding.
package sar_pkg;

    localparam int SAR_NBITS = 12;

    typedef enum logic [1:0] {
        MODE_RAMP_UP = 2'b00,
        MODE_LFSR    = 2'b01,
        MODE_FIXED   = 2'b10,
        MODE_RAMP_DN = 2'b11
    } sar_mode_e;

    localparam logic [SAR_NBITS-1:0] LFSR_TAPS = 12'h853;
    localparam logic [SAR_NBITS-1:0] LFSR_SEED = 12'h001;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SAMPLE = 2'b01,
        TRACK  = 2'b10,
        CHECK  = 2'b11
    } sar_state_e;

    // One right-shifting Galois step; the all-zero state is never reached.
    function automatic logic [SAR_NBITS-1:0] lfsr_next(input logic [SAR_NBITS-1:0] s);
        logic [SAR_NBITS-1:0] t;
        t = {1'b0, s[SAR_NBITS-1:1]};
        if (s[0]) begin
            t = t ^ LFSR_TAPS;
        end else begin
            t = t;
        end
        return t;
    endfunction

endpackage

// File: rtl/sar_cmp_responder_if.sv
// Comparator link between sarlogic (master) and the responder (slave).
interface sar_link_if import sar_pkg::*; #(
    parameter int NBITS = SAR_NBITS
) ();
    logic [NBITS-1:0] trial_code;
    logic             conv_done;
    logic             cmp_out;

    modport master (output trial_code, output conv_done, input cmp_out);
    modport slave  (input trial_code, input conv_done, output cmp_out);
endinterface

// File: rtl/sar_stim_gen.sv
// Stimulus source for the responder: ramp up/down, Galois LFSR or fixed code,
// seeded by load and stepped by advance.
module sar_stim_gen import sar_pkg::*; #(
    parameter int NBITS = SAR_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] cfg_code,
    output logic [NBITS-1:0] stim
);

    localparam logic [NBITS-1:0] STEP = {{(NBITS-1){1'b0}}, 1'b1};

    logic [NBITS-1:0] stim_r;
    logic [NBITS-1:0] lfsr_r;

    // Current code selection; fixed mode follows cfg_code live so a change lands at the next sample
    always_comb begin
        stim = stim_r;
        case (mode)
            MODE_FIXED: stim = cfg_code;
            MODE_LFSR:  stim = lfsr_r;
            default:    stim = stim_r;
        endcase
    end

    // Seed on load, step on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_r <= '0;
            lfsr_r <= LFSR_SEED;
        end else if (load) begin
            stim_r <= cfg_code;
            lfsr_r <= (cfg_code == '0) ? LFSR_SEED : cfg_code;
        end else if (advance) begin
            case (mode)
                MODE_RAMP_UP: stim_r <= stim_r + STEP;
                MODE_RAMP_DN: stim_r <= stim_r - STEP;
                MODE_FIXED:   stim_r <= cfg_code;
                MODE_LFSR:    lfsr_r <= lfsr_next(lfsr_r);
                default:      stim_r <= stim_r;
            endcase
        end
    end

endmodule

// File: rtl/sar_cmp_responder.sv
// BIST comparator/DAC responder for the SAR loop: holds a synthetic input code,
// answers trial codes, and scores every finished conversion.
module sar_cmp_responder import sar_pkg::*; #(
    parameter int NBITS   = SAR_NBITS,
    parameter int CMP_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] cfg_code,
    sar_link_if.slave        link,
    output logic [NBITS-1:0] vin_code,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sar_state_e       state_r, state_s;
    logic             enable_d_r;
    logic             first_r;
    logic             chk_pass_r, chk_fail_r;
    logic [NBITS-1:0] vin_r;
    logic [CNT_W-1:0] pass_r, err_r;
    logic [NBITS-1:0] stim_s;
    logic             enable_rise_s, load_s, advance_s, track_s, check_s;
    logic             conv_hit_s, cmp_raw_s;

    assign enable_rise_s = enable & ~enable_d_r;
    assign conv_hit_s    = track_s & enable & link.conv_done;

    sar_stim_gen #(.NBITS(NBITS)) u_stim (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .advance  (advance_s),
        .mode     (mode),
        .cfg_code (cfg_code),
        .stim     (stim_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere
    always_comb begin
        state_s = state_r;
        if (!enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = enable_rise_s ? SAMPLE : IDLE;
                SAMPLE:  state_s = TRACK;
                TRACK:   state_s = link.conv_done ? CHECK : TRACK;
                CHECK:   state_s = SAMPLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Per-state strobes
    always_comb begin
        load_s    = 1'b0;
        advance_s = 1'b0;
        track_s   = 1'b0;
        check_s   = 1'b0;
        case (state_r)
            IDLE:    load_s    = enable_rise_s;
            SAMPLE:  advance_s = enable;
            TRACK:   track_s   = 1'b1;
            CHECK:   check_s   = enable;
            default: load_s    = 1'b0;
        endcase
    end

    // Held input code, result capture and the discard-first-conversion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_d_r <= 1'b0;
            first_r    <= 1'b0;
            vin_r      <= '0;
            chk_pass_r <= 1'b0;
            chk_fail_r <= 1'b0;
        end else begin
            enable_d_r <= enable;
            if (load_s) begin
                first_r <= 1'b1;
            end else if (conv_hit_s) begin
                first_r <= 1'b0;
            end
            if (advance_s) begin
                vin_r <= stim_s;
            end
            chk_pass_r <= conv_hit_s & ~first_r & (link.trial_code == vin_r);
            chk_fail_r <= conv_hit_s & ~first_r & (link.trial_code != vin_r);
        end
    end

    // Saturating score counters, updated only in an enabled CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r <= '0;
            err_r  <= '0;
        end else if (check_s) begin
            if (chk_pass_r && (pass_r != CNT_MAX)) begin
                pass_r <= pass_r + CNT_ONE;
            end
            if (chk_fail_r && (err_r != CNT_MAX)) begin
                err_r <= err_r + CNT_ONE;
            end
        end
    end

    assign cmp_raw_s = track_s & (vin_r >= link.trial_code);

    generate
        if (CMP_LAT == 0) begin : g_cmp_comb
            assign link.cmp_out = cmp_raw_s;
        end else begin : g_cmp_pipe
            logic [CMP_LAT-1:0] pipe_r;

            // Comparator delay line, flushed whenever not tracking
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_r <= '0;
                end else if (!track_s) begin
                    pipe_r <= '0;
                end else begin
                    pipe_r[0] <= cmp_raw_s;
                    for (int i = 1; i < CMP_LAT; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign link.cmp_out = pipe_r[CMP_LAT-1] & track_s;
        end
    endgenerate

    assign vin_code = vin_r;
    assign mismatch = chk_fail_r;
    assign pass_cnt = pass_r;
    assign err_cnt  = err_r;

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Scoreboard bench: a behavioural SAR master drives two responders
// (combinational 16-bit counters, and 2-cycle latency with 2-bit counters).
module tb_sar_cmp_responder;
    import sar_pkg::*;

    localparam int NB = SAR_NBITS;

    typedef struct {
        logic [NB-1:0] vin;
        bit            counted;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [NB-1:0] cfg_code = '0;
    logic [NB-1:0] trial = '0;
    logic          conv_done = 1'b0;

    logic [NB-1:0] vin0, vin2;
    logic          mm0, mm2;
    logic [15:0]   pass0, err0;
    logic [1:0]    pass2, err2;

    sar_link_if #(.NBITS(NB)) lk0 ();
    sar_link_if #(.NBITS(NB)) lk2 ();

    assign lk0.trial_code = trial;
    assign lk0.conv_done  = conv_done;
    assign lk2.trial_code = trial;
    assign lk2.conv_done  = conv_done;

    sar_cmp_responder #(.NBITS(NB), .CMP_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .cfg_code(cfg_code),
        .link(lk0.slave), .vin_code(vin0), .mismatch(mm0), .pass_cnt(pass0), .err_cnt(err0)
    );

    sar_cmp_responder #(.NBITS(NB), .CMP_LAT(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .cfg_code(cfg_code),
        .link(lk2.slave), .vin_code(vin2), .mismatch(mm2), .pass_cnt(pass2), .err_cnt(err2)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t cur;
    logic [NB-1:0] m_stim, m_lfsr;
    int   e_pass0 = 0, e_err0 = 0, e_pass2 = 0, e_err2 = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] lfsr_ref(input logic [NB-1:0] s);
        logic [NB-1:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 12'h853;
        return t;
    endfunction

    task automatic check_counts(input string tag);
        check_eq({tag, "_pass0"}, 32'(pass0), 32'(e_pass0));
        check_eq({tag, "_err0"},  32'(err0),  32'(e_err0));
        check_eq({tag, "_pass2"}, 32'(pass2), 32'(e_pass2));
        check_eq({tag, "_err2"},  32'(err2),  32'(e_err2));
    endtask

    // Restart the responder with a new stimulus and queue the n codes it should hold
    task automatic start_run(input logic [1:0] md, input logic [NB-1:0] cfg, input int n);
        exp_t e;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        mode = md;
        cfg_code = cfg;
        enable = 1'b1;
        sb_q.delete();
        m_stim = cfg;
        m_lfsr = (cfg == 12'h000) ? 12'h001 : cfg;
        for (int i = 0; i < n; i++) begin
            e.counted = (i != 0);
            case (md)
                MODE_FIXED: e.vin = cfg;
                MODE_LFSR:  e.vin = m_lfsr;
                default:    e.vin = m_stim;
            endcase
            case (md)
                MODE_RAMP_UP: m_stim = m_stim + 12'd1;
                MODE_RAMP_DN: m_stim = m_stim - 12'd1;
                MODE_LFSR:    m_lfsr = lfsr_ref(m_lfsr);
                default:      m_stim = cfg;
            endcase
            sb_q.push_back(e);
        end
    endtask

    task automatic conv_begin();
        repeat (2) @(negedge clk);
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) cur = sb_q.pop_front();
        check_eq("vin0", 32'(vin0), 32'(cur.vin));
        check_eq("vin2", 32'(vin2), 32'(cur.vin));
        check_counts("cnt");
    endtask

    task automatic conv_search(output logic [NB-1:0] res);
        res = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            trial = res | (12'd1 << b);
            #1;
            if (lk0.cmp_out) res = trial;
            @(negedge clk);
        end
    endtask

    task automatic conv_end(input logic [NB-1:0] fin);
        bit exp_mm;
        trial = fin;
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        exp_mm = cur.counted && (fin != cur.vin);
        if (cur.counted) begin
            if (fin == cur.vin) begin
                if (e_pass0 < 65535) e_pass0++;
                if (e_pass2 < 3) e_pass2++;
            end else begin
                if (e_err0 < 65535) e_err0++;
                if (e_err2 < 3) e_err2++;
            end
        end
        check_eq("mismatch0", 32'(mm0), 32'(exp_mm));
        check_eq("mismatch2", 32'(mm2), 32'(exp_mm));
    endtask

    task automatic loop_conv();
        logic [NB-1:0] r;
        conv_begin();
        conv_search(r);
        check_eq("loop_result", 32'(r), 32'(cur.vin));
        conv_end(r);
    endtask

    task automatic probe(input string tag, input logic [NB-1:0] t, input bit exp0);
        trial = t;
        #1;
        check_eq(tag, 32'(lk0.cmp_out), 32'(exp0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_vin0", 32'(vin0), 32'd0);
        check_eq("rst_vin2", 32'(vin2), 32'd0);
        check_eq("rst_mm0", 32'(mm0), 32'd0);
        check_eq("rst_cmp0", 32'(lk0.cmp_out), 32'd0);
        check_eq("rst_cmp2", 32'(lk2.cmp_out), 32'd0);
        check_counts("rst");
        rst_n = 1'b1;

        // Fixed code looped through the SAR master; first conversion discarded
        start_run(MODE_FIXED, 12'hA5C, 4);
        repeat (4) loop_conv();

        // Ramp up across the wrap, then ramp down across it
        start_run(MODE_RAMP_UP, 12'hFFE, 4);
        repeat (4) loop_conv();
        start_run(MODE_RAMP_DN, 12'h001, 3);
        repeat (3) loop_conv();

        // LFSR with zero seed falls back to 12'h001
        start_run(MODE_LFSR, 12'h000, 3);
        repeat (3) loop_conv();

        // Open-loop threshold and 2-cycle comparator latency at vin=12'h800
        start_run(MODE_FIXED, 12'h800, 2);
        conv_begin();
        trial = 12'h800;
        repeat (3) @(negedge clk);
        probe("thr_800", 12'h800, 1'b1);
        check_eq("lat2_settled", 32'(lk2.cmp_out), 32'd1);
        @(negedge clk);
        probe("thr_801", 12'h801, 1'b0);
        check_eq("lat2_lag0", 32'(lk2.cmp_out), 32'd1);
        @(negedge clk);
        #1 check_eq("lat2_lag1", 32'(lk2.cmp_out), 32'd1);
        @(negedge clk);
        #1 check_eq("lat2_lag2", 32'(lk2.cmp_out), 32'd0);
        conv_end(12'h800);
        loop_conv();

        // Boundary codes
        start_run(MODE_FIXED, 12'h000, 2);
        conv_begin();
        probe("vin0_t0", 12'h000, 1'b1);
        @(negedge clk);
        probe("vin0_t1", 12'h001, 1'b0);
        conv_end(12'h000);
        loop_conv();
        start_run(MODE_FIXED, 12'hFFF, 2);
        conv_begin();
        probe("vinmax_t0", 12'h000, 1'b1);
        @(negedge clk);
        probe("vinmax_tmax", 12'hFFF, 1'b1);
        conv_end(12'hFFF);
        loop_conv();

        // Forced wrong result: single-cycle mismatch pulse, err count only
        start_run(MODE_FIXED, 12'h124, 2);
        loop_conv();
        conv_begin();
        conv_end(12'h123);
        @(negedge clk);
        check_eq("mm_pulse_end", 32'(mm0), 32'd0);
        check_counts("after_err");

        // Asynchronous reset in the middle of TRACK
        start_run(MODE_RAMP_UP, 12'h010, 2);
        conv_begin();
        probe("pre_rst_cmp", 12'h005, 1'b1);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        e_pass0 = 0; e_err0 = 0; e_pass2 = 0; e_err2 = 0;
        check_eq("arst_cmp0", 32'(lk0.cmp_out), 32'd0);
        check_eq("arst_vin0", 32'(vin0), 32'd0);
        check_eq("arst_mm0", 32'(mm0), 32'd0);
        check_counts("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Enable dropped mid-TRACK: IDLE, vin and counters held
        start_run(MODE_RAMP_UP, 12'h010, 2);
        conv_begin();
        probe("pre_dis_cmp", 12'h005, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        #1;
        check_eq("dis_cmp0", 32'(lk0.cmp_out), 32'd0);
        check_eq("dis_vin0", 32'(vin0), 32'h010);
        check_counts("dis");

        // Re-enable resumes from the seed
        start_run(MODE_RAMP_UP, 12'h010, 2);
        repeat (2) loop_conv();
        repeat (2) @(negedge clk);
        check_counts("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
